resilient_stage_scheduler: RTL
==============================

Name: resilient_stage_scheduler

Overview:
Clocked scheduler that shares one error-detecting (timing-resilient) pipeline stage among N_REQ requesters.
- Requester side: 4-phase req/ack per requester, served round-robin.
- Stage side: one 4-phase transaction per grant (st_req/st_ack).
- When the stage flags a timing error (st_err0/st_err1), the scheduler replays the transaction up to RETRY_MAX times, then releases the requester with a fail indication.
- Sits between the requesting units and the shared stage's handshake controller.

Parameters:
N_REQ, 4, number of requesters (≥2)
RETRY_MAX, 3, replays allowed after the first failed attempt
TIMEOUT, 15, cycles in ISSUE without st_ack before abort
CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-high
req  in  N_REQ  per-requester 4-phase request (level)
ack  out  N_REQ  per-requester 4-phase acknowledge, one-hot or zero
grant_id  out  $clog2(N_REQ)  index of requester currently served
st_req  out  1  request to shared stage
st_ack  in  1  stage acknowledge
st_err0  in  1  stage early-error flag, valid on cycles where st_ack=1
st_err1  in  1  stage late-error flag, valid on cycles where st_ack=1
replay  out  1  one-cycle pulse when a retry is launched
fail  out  1  level; high with ack when retries exhausted or timeout
busy  out  1  high in every state except IDLE
err_cnt  out  CNT_W  saturating count of error events

Behaviour:
- Input timing: all inputs are synchronous to clk; synchronisation is outside this block. All outputs are registered.
- Reset values: ack=0, st_req=0, grant_id=0, replay=0, fail=0, busy=0, err_cnt=0, rr pointer=0, retry count=0, timeout count=0, state=IDLE. Reset takes effect immediately in any state; st_req drops without waiting for st_ack.
- IDLE:
  - If any req bit is high, select the first set bit at or after the rr pointer (wrapping), register grant_id, clear retry/timeout counters, go to ISSUE.
  - st_req rises at the edge after req is first sampled high (1-cycle latency).
- ISSUE: st_req=1; timeout count increments every cycle.
  - st_ack=1 with no error flag → RTZ_OK.
  - st_ack=1 with st_err0|st_err1 → err_cnt+1 (one count even if both flags are set), → RTZ_ERR.
  - Timeout count reaches TIMEOUT with st_ack=0 → err_cnt+1, set fail flag, → RTZ_ERR with retries treated as exhausted.
- RTZ_OK / RTZ_ERR: st_req=0; stay until st_ack=0.
  - RTZ_OK then → HANDOFF with fail=0.
  - RTZ_ERR then: if retry < RETRY_MAX and no timeout: retry+1, replay=1 for one cycle, clear timeout count, → ISSUE. Otherwise → HANDOFF with fail=1.
- HANDOFF:
  - ack[grant_id]=1; fail holds its value.
  - When req[grant_id]=0 is sampled: ack=0, fail=0, rr pointer=grant_id+1 mod N_REQ, → IDLE.
- Max attempts per grant: 1+RETRY_MAX stage transactions.
- Other requesters: req changes from non-granted requesters are ignored until IDLE. A granted requester dropping req before ack violates protocol; the scheduler still completes the transaction and passes through HANDOFF in one cycle.
- err_cnt saturates at 2^CNT_W−1 and never wraps. It is cleared only by rst.
- Fairness: a requester re-asserting req immediately after its ack falls is served after every other pending requester.
- RTZ waits have no timeout. A stuck st_ack holds the block in RTZ; rst is the only recovery.

Decomposition:
- Shared package: state enum (IDLE, ISSUE, RTZ_OK, RTZ_ERR, HANDOFF), an IDW=$clog2(N_REQ) helper, and saturating-increment function.
- One sub-module: rr_arbiter. Combinational round-robin pick from (req vector, pointer) returning index and valid; parameterised by N_REQ.

Test Plan:
- Single clean transfer: req=0001; stage acks after 3 cycles, no errors.
  → st_req 1 cycle after req; ack=0001, fail=0, err_cnt=0, pointer=1 after req drops.
- Round-robin: req=1111 held; each grant completed cleanly.
  → grant_id sequence 0,1,2,3,0; no requester served twice before the others.
- Single retry: requester 2; first st_ack with st_err1=1, second clean.
  → replay pulses once, two st_req rise edges, ack[2]=1, fail=0, err_cnt=1.
- Retries exhausted: every st_ack with st_err0=st_err1=1, RETRY_MAX=3.
  → 4 stage transactions, 3 replay pulses, err_cnt=4, ack with fail=1.
- Timeout: st_ack never rises.
  → st_req held exactly TIMEOUT cycles, then drops; err_cnt+1, ack with fail=1, no replay.
- Reset mid-ISSUE plus saturation: assert rst with st_req=1 → all outputs 0 asynchronously and state IDLE. Then, with CNT_W=2, 5 error events → err_cnt stops at 3.

Source files
------------

// File: rtl/resilient_stage_scheduler_pkg.sv
// Shared types and helpers for the resilient stage scheduler.
// FSM encoding, index-width helper and saturating increment.
package resilient_stage_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RTZ_OK,
    RTZ_ERR,
    HANDOFF
  } sched_state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max_v
  );
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/resilient_stage_scheduler_if.sv
// Requester and shared-stage handshake bundle.
// slave is the scheduler side, master the environment side.
interface resilient_stage_scheduler_if
  import resilient_stage_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  localparam int IDW = idw(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic [IDW-1:0]   grant_id;
  logic             st_req;
  logic             st_ack;
  logic             st_err0;
  logic             st_err1;
  logic             replay;
  logic             fail;
  logic             busy;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output req,
    output st_ack,
    output st_err0,
    output st_err1,
    input  ack,
    input  grant_id,
    input  st_req,
    input  replay,
    input  fail,
    input  busy,
    input  err_cnt
  );

  modport slave (
    input  req,
    input  st_ack,
    input  st_err0,
    input  st_err1,
    output ack,
    output grant_id,
    output st_req,
    output replay,
    output fail,
    output busy,
    output err_cnt
  );

endinterface

// File: rtl/resilient_stage_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or after the pointer, wrapping around.
module resilient_stage_scheduler_rr_arbiter
  import resilient_stage_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDW = idw(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   idx,
  output logic             valid
);

  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/resilient_stage_scheduler.sv
// Shares one error-detecting stage among N_REQ requesters,
// replaying failed transactions and reporting exhaustion.
module resilient_stage_scheduler
  import resilient_stage_scheduler_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  resilient_stage_scheduler_if.slave bus
);

  localparam int IDW = idw(N_REQ);
  localparam int RW  = idw(RETRY_MAX + 1);
  localparam int TW  = idw(TIMEOUT + 1);
  localparam logic [31:0] CNT_MAX =
    32'((64'd1 << CNT_W) - 64'd1);

  sched_state_t     state_q, state_n;
  logic [IDW-1:0]   ptr_q, ptr_n;
  logic [IDW-1:0]   gnt_q, gnt_n;
  logic [RW-1:0]    retry_q, retry_n;
  logic [TW-1:0]    tcnt_q, tcnt_n;
  logic             abort_q, abort_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [N_REQ-1:0] ack_q, ack_n;
  logic             fail_q, fail_n;
  logic             replay_q, replay_n;
  logic             st_req_q;
  logic             busy_q;

  logic [IDW-1:0]   pick_idx;
  logic             pick_vld;
  logic             st_err;

  resilient_stage_scheduler_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign st_err  = bus.st_err0 | bus.st_err1;
  assign cnt_inc =
    CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));

  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    gnt_n    = gnt_q;
    retry_n  = retry_q;
    tcnt_n   = tcnt_q;
    abort_n  = abort_q;
    cnt_n    = cnt_q;
    fail_n   = fail_q;
    replay_n = 1'b0;
    ack_n    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_n   = pick_idx;
          retry_n = '0;
          tcnt_n  = '0;
          abort_n = 1'b0;
          fail_n  = 1'b0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_n = tcnt_q + 1'b1;
        if (bus.st_ack) begin
          if (st_err) begin
            cnt_n   = cnt_inc;
            state_n = RTZ_ERR;
          end else begin
            state_n = RTZ_OK;
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // Timeout counts as an error and forbids replay.
          cnt_n   = cnt_inc;
          abort_n = 1'b1;
          state_n = RTZ_ERR;
        end
      end
      RTZ_OK: begin
        if (!bus.st_ack) begin
          fail_n  = 1'b0;
          state_n = HANDOFF;
        end
      end
      RTZ_ERR: begin
        if (!bus.st_ack) begin
          if (!abort_q && retry_q < RW'(RETRY_MAX)) begin
            retry_n  = retry_q + 1'b1;
            replay_n = 1'b1;
            tcnt_n   = '0;
            state_n  = ISSUE;
          end else begin
            fail_n  = 1'b1;
            state_n = HANDOFF;
          end
        end
      end
      HANDOFF: begin
        if (!bus.req[gnt_q]) begin
          fail_n  = 1'b0;
          ptr_n   = (gnt_q == IDW'(N_REQ - 1)) ?
                    '0 : gnt_q + 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == HANDOFF) ack_n[gnt_n] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      retry_q  <= '0;
      tcnt_q   <= '0;
      abort_q  <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      fail_q   <= 1'b0;
      replay_q <= 1'b0;
      st_req_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      ptr_q    <= ptr_n;
      gnt_q    <= gnt_n;
      retry_q  <= retry_n;
      tcnt_q   <= tcnt_n;
      abort_q  <= abort_n;
      cnt_q    <= cnt_n;
      ack_q    <= ack_n;
      fail_q   <= fail_n;
      replay_q <= replay_n;
      st_req_q <= (state_n == ISSUE);
      busy_q   <= (state_n != IDLE);
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = gnt_q;
  assign bus.st_req   = st_req_q;
  assign bus.replay   = replay_q;
  assign bus.fail     = fail_q;
  assign bus.busy     = busy_q;
  assign bus.err_cnt  = cnt_q;

endmodule
